bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double dabble); inverse of the
//  display-side binary-to-BCD path. Takes decimal digits entered on slide
//  switches / digit registers and returns the binary value, one bit per clock,
//  with a start/busy/done handshake. Feeds counter preload and compare logic.
// PARAMETERS
//  DIGITS  3   number of BCD digits at input (digit 0 = ones, in bits [3:0])
//  BIN_W   10  binary result width; also the number of shift steps
// PORTS
//  clk      in   1           system clock
//  rst      in   1           asynchronous reset, active-low
//  start    in   1           request conversion; sampled only in IDLE
//  bcd_in   in   4*DIGITS    packed BCD operand, digit k = bcd_in[4k+3:4k]
//  busy     out  1           high while a conversion is in progress
//  done     out  1           one-cycle pulse: bin_out/err/ovf valid
//  bin_out  out  BIN_W       binary result, held until next done
//  err      out  1           invalid digit (>9) in last operand, held
//  ovf      out  1           last value exceeded 2^BIN_W-1, held
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; busy=0, done=0, bin_out=0, err=0, ovf=0;
//   internal shift registers and step counter cleared. Reset mid-conversion
//   aborts it; no done pulse follows.
//  States: IDLE -> SHIFT -> DONE -> IDLE; invalid operand: IDLE -> DONE.
//  IDLE: on start=1 at edge T0, capture bcd_in; if any digit >9 go DONE with
//   err flagged, else load BCD reg, clear bin reg, step=0, go SHIFT. busy=1
//   from T0+1.
//  SHIFT (BIN_W cycles): each cycle shift {bcd_reg,bin_reg} right by 1 (LSB of
//   bcd_reg enters MSB of bin_reg), then for every digit of the shifted bcd_reg
//   with value >=8 subtract 3. step increments; after step BIN_W-1 go DONE.
//  DONE (1 cycle): done=1, busy=0; bin_out=bin_reg; ovf=1 iff residual bcd_reg
//   !=0; err per operand check. Invalid operand: bin_out=0, ovf=0, err=1.
//  Latency: valid operand done at T0+BIN_W+1; invalid operand done at T0+1.
//  start while busy or in DONE is ignored (no queueing). start held high in
//   IDLE after done starts a new conversion on the next edge.
//  bcd_in may change after T0 without affecting the running conversion.
//  err/ovf/bin_out change only in the DONE cycle.
//  Arithmetic: digit correction is 4-bit, unsigned; no carry between digits.
//  Max valid input 10^DIGITS-1; ovf only possible when that exceeds 2^BIN_W-1.
// TESTING
//  1. defaults, bcd_in=12'h255, start 1 cycle -> busy 10 cycles, done at T0+11,
//     bin_out=10'd255, err=0, ovf=0.
//  2. bcd_in=12'h999 -> bin_out=10'd999 (0x3E7); bcd_in=12'h000 -> bin_out=0,
//     done still at T0+11.
//  3. bcd_in=12'h1A3 -> done at T0+1, err=1, bin_out=0, ovf=0; following valid
//     12'h042 clears err, bin_out=42.
//  4. BIN_W=8: bcd_in=12'h256 -> ovf=1; bcd_in=12'h255 -> ovf=0, bin_out=8'hFF.
//  5. start pulsed again at T0+3 with different bcd_in -> ignored; single done
//     at T0+11 with first operand's result.
//  6. rst low at T0+5 -> busy=0, all outputs 0 immediately; no done pulse;
//     new start after release converts correctly.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq
//   Sequential BCD-to-binary converter using reverse double dabble. A packed
//   BCD operand is captured on start, then shifted right one bit per clock
//   into a binary register. After each shift, every BCD digit that is 8 or
//   more has 3 subtracted. Operands containing a digit above 9 are rejected
//   straight away with err set.
//
// Parameters
//   DIGITS  number of BCD digits at bcd_in (digit 0 = ones, bits [3:0])
//   BIN_W   binary result width and number of shift steps (>= 2)
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active-low
//   start    conversion request, sampled only in IDLE
//   bcd_in   packed BCD operand, digit k = bcd_in[4k+3:4k]
//   busy     high while a conversion is shifting
//   done     one-cycle pulse; bin_out/err/ovf valid from this cycle on
//   bin_out  binary result, held until the next done
//   err      last operand contained a digit > 9, held
//   ovf      last operand exceeded 2^BIN_W-1, held
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  ovf
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [BCD_W-1:0]  bcd_reg;
  logic [BIN_W-1:0]  bin_reg;
  logic [STEP_W-1:0] step;

  logic [BCD_W-1:0]  bcd_nxt;
  logic [BIN_W-1:0]  bin_nxt;

  // Flags any nibble outside 0..9.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Per-digit correction after a right shift: a digit >= 8 received a
  // borrowed "ten" from the digit above as weight 8, which must become 5.
  // Each digit is corrected independently; no carry crosses digit bounds.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (d >= 4'd8) d = d - 4'd3;
      r[4*k +: 4] = d;
    end
    return r;
  endfunction

  // One step of the {bcd_reg, bin_reg} right shift with digit correction.
  always_comb begin
    bin_nxt = {bcd_reg[0], bin_reg[BIN_W-1:1]};
    bcd_nxt = correct_digits(bcd_reg >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      bcd_reg <= '0;
      bin_reg <= '0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (has_bad_digit(bcd_in)) begin
              // Reject immediately; results are published on entry to DONE.
              state   <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              ovf     <= 1'b0;
              bin_out <= '0;
            end else begin
              state   <= SHIFT;
              busy    <= 1'b1;
              bcd_reg <= bcd_in;
              bin_reg <= '0;
              step    <= '0;
            end
          end
        end

        SHIFT: begin
          bcd_reg <= bcd_nxt;
          bin_reg <= bin_nxt;
          step    <= step + STEP_W'(1);
          if (step == LAST_STEP) begin
            // Any value left in the BCD register did not fit in BIN_W bits.
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bin_out <= bin_nxt;
            ovf     <= |bcd_nxt;
            err     <= 1'b0;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq
//   Directed bench for bcd2bin_seq. Instance a uses the default BIN_W=10 and
//   instance b uses BIN_W=8 for the overflow cases. Outputs are sampled on
//   the falling edge, and inputs are driven there too.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [11:0] bcd_a, bcd_b;
  logic        busy_a, done_a, err_a, ovf_a;
  logic        busy_b, done_b, err_b, ovf_b;
  logic [9:0]  bin_a;
  logic [7:0]  bin_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bcd_in(bcd_a),
    .busy(busy_a), .done(done_a), .bin_out(bin_a), .err(err_a), .ovf(ovf_a)
  );

  bcd2bin_seq #(.DIGITS(3), .BIN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bcd_in(bcd_b),
    .busy(busy_b), .done(done_b), .bin_out(bin_b), .err(err_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Issue one start pulse and wait (bounded) for done. lat counts falling
  // edges after the start edge T0; bcnt counts sampled busy cycles.
  task automatic run(input bit sel, input logic [11:0] bcd,
                     output int lat, output int bcnt,
                     output logic [9:0] bin, output logic e, output logic o);
    @(negedge clk);
    if (sel) begin start_b = 1'b1; bcd_b = bcd; end
    else     begin start_a = 1'b1; bcd_a = bcd; end
    @(posedge clk);
    @(negedge clk);
    // Operand changes after capture must not affect the conversion.
    start_a = 1'b0; start_b = 1'b0; bcd_a = 12'hFFF; bcd_b = 12'hFFF;
    lat  = 1;
    bcnt = 0;
    while (!(sel ? done_b : done_a) && lat < 40) begin
      if (sel ? busy_b : busy_a) bcnt++;
      @(negedge clk);
      lat++;
    end
    bin = sel ? {2'b00, bin_b} : bin_a;
    e   = sel ? err_b : err_a;
    o   = sel ? ovf_b : ovf_a;
  endtask

  int          lat, bcnt, ndone, done_at;
  logic [9:0]  bin;
  logic        e, o;

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; bcd_a = '0; bcd_b = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_bin",  32'(bin_a),  0);
    chk("rst_err",  32'(err_a),  0);
    chk("rst_ovf",  32'(ovf_a),  0);
    @(negedge clk);
    rst = 1'b1;

    // 255 -> 255, busy for 10 cycles, done at T0+11
    run(1'b0, 12'h255, lat, bcnt, bin, e, o);
    chk("t1_lat",  32'(lat),  11);
    chk("t1_busy", 32'(bcnt), 10);
    chk("t1_bin",  32'(bin),  255);
    chk("t1_err",  32'(e),    0);
    chk("t1_ovf",  32'(o),    0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done_a), 0);
    chk("t1_bin_held",   32'(bin_a),  255);

    // 999 -> 0x3E7, 000 -> 0 with same latency
    run(1'b0, 12'h999, lat, bcnt, bin, e, o);
    chk("t2_999_bin", 32'(bin), 999);
    chk("t2_999_lat", 32'(lat), 11);
    run(1'b0, 12'h000, lat, bcnt, bin, e, o);
    chk("t2_0_bin", 32'(bin), 0);
    chk("t2_0_lat", 32'(lat), 11);

    // Invalid digit: immediate done with err
    run(1'b0, 12'h1A3, lat, bcnt, bin, e, o);
    chk("t3_lat",  32'(lat),  1);
    chk("t3_busy", 32'(bcnt), 0);
    chk("t3_err",  32'(e),    1);
    chk("t3_bin",  32'(bin),  0);
    chk("t3_ovf",  32'(o),    0);
    run(1'b0, 12'h042, lat, bcnt, bin, e, o);
    chk("t3_clr_err", 32'(e),   0);
    chk("t3_42_bin",  32'(bin), 42);

    // BIN_W=8: 256 overflows (low bits 0), 255 fits
    run(1'b1, 12'h256, lat, bcnt, bin, e, o);
    chk("t4_256_lat", 32'(lat), 9);
    chk("t4_256_ovf", 32'(o),   1);
    chk("t4_256_bin", 32'(bin), 0);
    run(1'b1, 12'h255, lat, bcnt, bin, e, o);
    chk("t4_255_ovf", 32'(o),   0);
    chk("t4_255_bin", 32'(bin), 255);

    // Second start during SHIFT is ignored
    @(negedge clk);
    start_a = 1'b1; bcd_a = 12'h123;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    ndone = 0; done_at = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) begin start_a = 1'b1; bcd_a = 12'h777; end
      if (n == 4) start_a = 1'b0;
      if (done_a) begin
        ndone++;
        done_at = n;
        chk("t5_bin", 32'(bin_a), 123);
      end
      @(negedge clk);
    end
    chk("t5_ndone",   32'(ndone),   1);
    chk("t5_done_at", 32'(done_at), 11);

    // Reset mid-conversion aborts and clears outputs (bin_out was 123)
    @(negedge clk);
    start_a = 1'b1; bcd_a = 12'h321;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_done", 32'(done_a), 0);
    chk("t6_bin",  32'(bin_a),  0);
    chk("t6_err",  32'(err_a),  0);
    chk("t6_ovf",  32'(ovf_a),  0);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done_a) ndone++; end
    rst = 1'b1;
    repeat (12) begin @(negedge clk); if (done_a) ndone++; end
    chk("t6_no_done", 32'(ndone), 0);
    run(1'b0, 12'h137, lat, bcnt, bin, e, o);
    chk("t6_after_bin", 32'(bin), 137);
    chk("t6_after_lat", 32'(lat), 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
